// File: rtl/wb_slave_ram.sv
// Wishbone classic-cycle slave: byte-wide RAM behind a base-address window,
// with a fixed number of wait states inserted before the single-cycle ack.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no transfer; waits for cyc & stb inside the address window
// ST_WAIT | request latched; counts down wait states, aborts if cyc/stb drop
// ST_ACK  | RAM accessed on entry; ack_o high for this one cycle
module wb_slave_ram #(
   parameter logic [15:0] ADDR_BASE   = 16'h0000,
   parameter int          ADDR_BITS   = 10,
   parameter int          WAIT_STATES = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cyc_i,
   input  logic        stb_i,
   input  logic        we_i,
   input  logic [15:0] adr_i,
   input  logic [7:0]  dat_i,
   output logic [7:0]  dat_o,
   output logic        ack_o,
   output logic        sel_o
);

   localparam int         DEPTH     = 1 << ADDR_BITS;
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACK
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [3:0]             wait_cnt;
   logic [3:0]             wait_cnt_nxt;
   logic [ADDR_BITS-1:0]   adr_q;
   logic                   we_q;
   logic [7:0]             dat_q;
   logic                   req;
   logic                   hit;
   logic                   latch_en;
   logic                   mem_access;
   logic [7:0]             mem [DEPTH];

   assign req   = cyc_i & stb_i;
   assign hit   = (adr_i[15:ADDR_BITS] == ADDR_BASE[15:ADDR_BITS]);
   assign sel_o = req & hit;

   // The counter runs down to zero and the access happens on the edge that
   // finds it at zero, so a zero-wait slave still acks one cycle after the
   // request edge and every transfer takes 2 + WAIT_STATES cycles.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      latch_en     = 1'b0;
      mem_access   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (sel_o) begin
               state_nxt    = ST_WAIT;
               wait_cnt_nxt = WAIT_LOAD;
               latch_en     = 1'b1;
            end
         end
         ST_WAIT: begin
            if (!req) begin
               state_nxt = ST_IDLE;
            end else if (wait_cnt == 4'd0) begin
               state_nxt  = ST_ACK;
               mem_access = 1'b1;
            end else begin
               wait_cnt_nxt = wait_cnt - 4'd1;
            end
         end
         ST_ACK: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= ST_IDLE;
         wait_cnt <= 4'd0;
         adr_q    <= '0;
         we_q     <= 1'b0;
         dat_q    <= 8'h00;
         ack_o    <= 1'b0;
         dat_o    <= 8'h00;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         ack_o    <= mem_access;
         if (latch_en) begin
            adr_q <= adr_i[ADDR_BITS-1:0];
            we_q  <= we_i;
            dat_q <= dat_i;
         end
         if (mem_access && !we_q) begin
            dat_o <= mem[adr_q];
         end
      end
   end

   // Storage is deliberately not reset; a reset mid-transfer forces ST_IDLE,
   // which removes mem_access before the next edge.
   always_ff @(posedge clk_i) begin
      if (mem_access && we_q) begin
         mem[adr_q] <= dat_q;
      end
   end

endmodule

// File: tb/tb_wb_slave_ram.sv
// Bench for wb_slave_ram: four instances cover 1, 0 and 3 wait states and an
// offset address window; read data is checked against a queue of expectations.
module tb_wb_slave_ram;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cyc [4];
   logic        stb [4];
   logic        we  [4];
   logic [15:0] adr [4];
   logic [7:0]  dwr [4];
   logic [7:0]  drd [4];
   logic        ack [4];
   logic        sel [4];

   logic [7:0]  model [4][1024];
   logic [7:0]  exp_q [$];
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   wb_slave_ram #(.ADDR_BASE(16'h0000), .ADDR_BITS(10), .WAIT_STATES(1)) u_ws1 (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]),
      .adr_i(adr[0]), .dat_i(dwr[0]), .dat_o(drd[0]), .ack_o(ack[0]), .sel_o(sel[0]));
   wb_slave_ram #(.ADDR_BASE(16'h0000), .ADDR_BITS(10), .WAIT_STATES(0)) u_ws0 (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]),
      .adr_i(adr[1]), .dat_i(dwr[1]), .dat_o(drd[1]), .ack_o(ack[1]), .sel_o(sel[1]));
   wb_slave_ram #(.ADDR_BASE(16'h0400), .ADDR_BITS(10), .WAIT_STATES(1)) u_win (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(we[2]),
      .adr_i(adr[2]), .dat_i(dwr[2]), .dat_o(drd[2]), .ack_o(ack[2]), .sel_o(sel[2]));
   wb_slave_ram #(.ADDR_BASE(16'h0000), .ADDR_BITS(10), .WAIT_STATES(3)) u_ws3 (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc[3]), .stb_i(stb[3]), .we_i(we[3]),
      .adr_i(adr[3]), .dat_i(dwr[3]), .dat_o(drd[3]), .ack_o(ack[3]), .sel_o(sel[3]));

   // One bounded transfer: drive at negedge, sample 1 time unit after each
   // rising edge; lat counts edges after the request edge until ack shows.
   task automatic xfer(input int d, input logic w, input logic [15:0] a,
                       input logic [7:0] wd, input int max_cyc,
                       output int lat, output logic [7:0] rd, output logic got,
                       output logic wide, output logic sel_seen);
      @(negedge clk);
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; dwr[d] = wd;
      #1 sel_seen = sel[d];
      lat = 0; rd = 8'h00; got = 1'b0; wide = 1'b0;
      for (int i = 1; i <= max_cyc; i++) begin
         @(posedge clk); #1;
         if (ack[d] === 1'b1) begin
            got = 1'b1; lat = i - 1; rd = drd[d];
            break;
         end
      end
      cyc[d] = 1'b0; stb[d] = 1'b0;
      if (got) begin
         @(posedge clk); #1;
         wide = ack[d];
      end
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      for (int d = 0; d < 4; d++) begin
         n_cmp++;
         if (ack[d] !== 1'b0) begin
            n_bad++; $display("FAIL reset_ack[%0d]: got %b expected 0", d, ack[d]);
         end
         n_cmp++;
         if (drd[d] !== 8'h00) begin
            n_bad++; $display("FAIL reset_dat[%0d]: got %h expected 00", d, drd[d]);
         end
      end
      cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 16'h0012;
      cyc[2] = 1'b1; stb[2] = 1'b1; adr[2] = 16'h0012;
      #1;
      n_cmp++;
      if (sel[0] !== 1'b1) begin
         n_bad++; $display("FAIL reset_sel_hit: got %b expected 1", sel[0]);
      end
      n_cmp++;
      if (sel[2] !== 1'b0) begin
         n_bad++; $display("FAIL reset_sel_miss: got %b expected 0", sel[2]);
      end
      stb[0] = 1'b0;
      #1;
      n_cmp++;
      if (sel[0] !== 1'b0) begin
         n_bad++; $display("FAIL reset_sel_nostb: got %b expected 0", sel[0]);
      end
      cyc[0] = 1'b0; cyc[2] = 1'b0; stb[2] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_write_read();
      int lat; logic [7:0] rd, e; logic got, wide, s;
      xfer(0, 1'b1, 16'h0012, 8'hA5, 20, lat, rd, got, wide, s);
      if (got) model[0][10'h012] = 8'hA5;
      n_cmp++;
      if (got !== 1'b1 || lat != 2) begin
         n_bad++; $display("FAIL wr_latency: got ack=%b lat=%0d expected ack=1 lat=2", got, lat);
      end
      n_cmp++;
      if (wide !== 1'b0) begin
         n_bad++; $display("FAIL wr_ack_width: got ack still %b expected 0", wide);
      end
      exp_q.push_back(model[0][10'h012]);
      xfer(0, 1'b0, 16'h0012, 8'h00, 20, lat, rd, got, wide, s);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== 1'b1 || lat != 2) begin
         n_bad++; $display("FAIL rd_latency: got ack=%b lat=%0d expected ack=1 lat=2", got, lat);
      end
      n_cmp++;
      if (rd !== e) begin
         n_bad++; $display("FAIL rd_data_12: got %h expected %h", rd, e);
      end
   endtask

   task automatic test_zero_wait();
      int lat; logic [7:0] rd, e; logic got, wide, s;
      xfer(1, 1'b1, 16'h0000, 8'h11, 20, lat, rd, got, wide, s);
      if (got) model[1][10'h000] = 8'h11;
      xfer(1, 1'b1, 16'h03FF, 8'h3C, 20, lat, rd, got, wide, s);
      if (got) model[1][10'h3FF] = 8'h3C;
      n_cmp++;
      if (got !== 1'b1 || lat != 1 || wide !== 1'b0) begin
         n_bad++; $display("FAIL ws0_wr: got ack=%b lat=%0d wide=%b expected 1/1/0", got, lat, wide);
      end
      exp_q.push_back(model[1][10'h3FF]);
      xfer(1, 1'b0, 16'h03FF, 8'h00, 20, lat, rd, got, wide, s);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== 1'b1 || lat != 1) begin
         n_bad++; $display("FAIL ws0_rd_latency: got ack=%b lat=%0d expected ack=1 lat=1", got, lat);
      end
      n_cmp++;
      if (rd !== e) begin
         n_bad++; $display("FAIL ws0_rd_3ff: got %h expected %h", rd, e);
      end
      exp_q.push_back(model[1][10'h000]);
      xfer(1, 1'b0, 16'h0000, 8'h00, 20, lat, rd, got, wide, s);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== 1'b1 || rd !== e) begin
         n_bad++; $display("FAIL ws0_rd_000: got ack=%b data=%h expected ack=1 data=%h", got, rd, e);
      end
   endtask

   task automatic test_window();
      int lat; logic [7:0] rd, e; logic got, wide, s;
      xfer(2, 1'b1, 16'h0012, 8'h5A, 20, lat, rd, got, wide, s);
      n_cmp++;
      if (s !== 1'b0) begin
         n_bad++; $display("FAIL win_miss_sel: got %b expected 0", s);
      end
      n_cmp++;
      if (got !== 1'b0) begin
         n_bad++; $display("FAIL win_miss_ack: got ack=%b expected none in 20 cycles", got);
      end
      xfer(2, 1'b1, 16'h0412, 8'h5A, 20, lat, rd, got, wide, s);
      if (got) model[2][10'h012] = 8'h5A;
      n_cmp++;
      if (s !== 1'b1) begin
         n_bad++; $display("FAIL win_hit_sel: got %b expected 1", s);
      end
      n_cmp++;
      if (got !== 1'b1 || lat != 2) begin
         n_bad++; $display("FAIL win_hit_ack: got ack=%b lat=%0d expected ack=1 lat=2", got, lat);
      end
      exp_q.push_back(model[2][10'h012]);
      xfer(2, 1'b0, 16'h0412, 8'h00, 20, lat, rd, got, wide, s);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== 1'b1 || rd !== e) begin
         n_bad++; $display("FAIL win_rd_412: got ack=%b data=%h expected ack=1 data=%h", got, rd, e);
      end
   endtask

   task automatic test_abort();
      int lat; logic [7:0] rd, e; logic got, wide, s, seen;
      xfer(3, 1'b1, 16'h0005, 8'h00, 20, lat, rd, got, wide, s);
      if (got) model[3][10'h005] = 8'h00;
      n_cmp++;
      if (got !== 1'b1 || lat != 4) begin
         n_bad++; $display("FAIL ws3_latency: got ack=%b lat=%0d expected ack=1 lat=4", got, lat);
      end
      seen = 1'b0;
      @(negedge clk);
      cyc[3] = 1'b1; stb[3] = 1'b1; we[3] = 1'b1; adr[3] = 16'h0005; dwr[3] = 8'hFF;
      repeat (2) begin @(posedge clk); #1; seen |= (ack[3] === 1'b1); end
      @(negedge clk) stb[3] = 1'b0;
      repeat (10) begin @(posedge clk); #1; seen |= (ack[3] === 1'b1); end
      cyc[3] = 1'b0;
      n_cmp++;
      if (seen !== 1'b0) begin
         n_bad++; $display("FAIL abort_ack: got ack pulse=%b expected 0", seen);
      end
      exp_q.push_back(model[3][10'h005]);
      xfer(3, 1'b0, 16'h0005, 8'h00, 20, lat, rd, got, wide, s);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== 1'b1 || rd !== e) begin
         n_bad++; $display("FAIL abort_rd_005: got ack=%b data=%h expected ack=1 data=%h", got, rd, e);
      end
   endtask

   task automatic test_latch_and_reset();
      int lat; logic [7:0] rd, e; logic got, wide, s, seen;
      xfer(0, 1'b1, 16'h0021, 8'h44, 20, lat, rd, got, wide, s);
      if (got) model[0][10'h021] = 8'h44;
      xfer(0, 1'b1, 16'h0030, 8'h55, 20, lat, rd, got, wide, s);
      if (got) model[0][10'h030] = 8'h55;
      @(negedge clk);
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 16'h0020; dwr[0] = 8'h77;
      @(negedge clk);
      adr[0] = 16'h0021; dwr[0] = 8'h99;
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (ack[0] === 1'b1) begin got = 1'b1; break; end
      end
      cyc[0] = 1'b0; stb[0] = 1'b0;
      if (got) model[0][10'h020] = 8'h77;
      n_cmp++;
      if (got !== 1'b1) begin
         n_bad++; $display("FAIL latch_ack: got ack=%b expected 1", got);
      end
      exp_q.push_back(model[0][10'h020]);
      xfer(0, 1'b0, 16'h0020, 8'h00, 20, lat, rd, got, wide, s);
      e = exp_q.pop_front();
      n_cmp++;
      if (rd !== e) begin
         n_bad++; $display("FAIL latch_rd_020: got %h expected %h", rd, e);
      end
      exp_q.push_back(model[0][10'h021]);
      xfer(0, 1'b0, 16'h0021, 8'h00, 20, lat, rd, got, wide, s);
      e = exp_q.pop_front();
      n_cmp++;
      if (rd !== e) begin
         n_bad++; $display("FAIL latch_rd_021: got %h expected %h", rd, e);
      end
      seen = 1'b0;
      @(negedge clk);
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 16'h0030; dwr[0] = 8'hEE;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (ack[0] !== 1'b0 || drd[0] !== 8'h00) begin
         n_bad++; $display("FAIL midreset_outputs: got ack=%b dat=%h expected ack=0 dat=00", ack[0], drd[0]);
      end
      repeat (3) begin @(posedge clk); #1; seen |= (ack[0] === 1'b1); end
      @(negedge clk);
      cyc[0] = 1'b0; stb[0] = 1'b0; rst = 1'b0;
      repeat (5) begin @(posedge clk); #1; seen |= (ack[0] === 1'b1); end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_bad++; $display("FAIL midreset_ack: got ack pulse=%b expected 0", seen);
      end
      exp_q.push_back(model[0][10'h030]);
      xfer(0, 1'b0, 16'h0030, 8'h00, 20, lat, rd, got, wide, s);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== 1'b1 || rd !== e) begin
         n_bad++; $display("FAIL midreset_rd_030: got ack=%b data=%h expected ack=1 data=%h", got, rd, e);
      end
   endtask

   initial begin
      for (int d = 0; d < 4; d++) begin
         cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
         adr[d] = 16'h0000; dwr[d] = 8'h00;
      end
      test_reset();
      test_write_read();
      test_zero_wait();
      test_window();
      test_abort();
      test_latch_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

endmodule
